systolic_seq_ctrl: RTL
======================

Name: systolic_seq_ctrl

Overview:
Sequencing controller for the systolic alignment array. It streams the query in N-base blocks into the PE S registers and, for each block, streams the full reference through T. It drives the array's ack/s_update/valid/new_seq handshake and waits for the array to drain before starting the next block. At the end it publishes PE_end for traceback position capture and pulses done.

Parameters:
N, 64, number of PEs in the array
LOG_N, 6, log2(N)
BP_WIDTH, 2, bits per base
ADDRESS_WIDTH, 11, width of reference length/address
MAX_BLOCKS, 8, max query blocks (matches array memory blocks)
BLK_WIDTH, 3, log2(MAX_BLOCKS)

Ports:
clk  in  1  clock
reset_i  in  1  asynchronous active-low reset
start  in  1  one-cycle request to align; sampled only in IDLE
q_len  in  LOG_N+BLK_WIDTH+1  query length in bases; sampled on start
r_len  in  ADDRESS_WIDTH  reference length in bases; sampled on start
q_addr  out  LOG_N+BLK_WIDTH  query buffer read address
q_data  in  BP_WIDTH  query base; valid 1 cycle after q_addr
r_addr  out  ADDRESS_WIDTH  reference buffer read address
r_data  in  BP_WIDTH  reference base; valid 1 cycle after r_addr
S  out  BP_WIDTH  query base to array
T  out  BP_WIDTH  reference base to array
s_update  out  1  S load strobe to array
valid  out  1  T valid to array
ack  out  1  block-start / mem-advance to array
new_seq  out  1  new alignment pulse to array
PE_end  out  LOG_N  index of PE holding last query base
array_busy  in  1  array busy (high during CALC)
block_num  out  BLK_WIDTH  current query block index
ctrl_busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on an illegal request, with done

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Blocks: nblk = ceil(q_len/N). PE_end = (q_len-1) mod N. PE_end is computed and registered on start and held until the next start.
- States: IDLE, ACK, LOAD_Q, STREAM_R, DRAIN, FIN.
- IDLE: when start=1:
  - q_len=0, r_len=0, or q_len>N*MAX_BLOCKS -> FIN with err=1.
  - Otherwise latch lengths, set new_seq=1 for 1 cycle, set block_num=0, go to ACK.
- ACK: ack=1 for exactly one cycle; q_addr=block_num*N; go to LOAD_Q.
- LOAD_Q: lasts N cycles, issuing q_addr = block_num*N + i for i = 0..N-1.
  - S and s_update come from a 1-cycle-registered copy, so s_update is high for exactly N consecutive cycles starting the cycle after LOAD_Q entry.
  - Bases with index >= q_len are driven as S=0 (padding).
  - On i=N-1, go to STREAM_R.
- STREAM_R: issues r_addr 0..r_len-1, one per cycle. T/valid are 1-cycle delayed, giving exactly r_len valid cycles, back-to-back with the last s_update cycle.
  - ack=1 during every cycle in which valid is high (advances array mem_cnt).
  - After the last address, go to DRAIN.
- DRAIN: waits for array_busy to be seen high, then low; once low, go on.
  - If block_num+1 < nblk: increment block_num and go to ACK.
  - Otherwise go to FIN.
  - There is no timeout; behaviour on a stuck array is undefined.
- FIN: done=1 for one cycle; go to IDLE.
- ctrl_busy = (state != IDLE).
- start while ctrl_busy is ignored.
- start and FIN in the same cycle: start is ignored, because the state is not IDLE.
- q_len exactly N*k: the last block is full and PE_end = N-1.
- Reset mid-operation: all outputs drop to 0 asynchronously; the next start begins a fresh sequence with new_seq.

Test Plan:
- q_len=64, r_len=10, N=64:
  - new_seq pulse, then 1 ack.
  - 64 s_update cycles with S = q_data[0..63].
  - 10 valid cycles with T = r_data[0..9], ack high alongside.
  - Hold DRAIN until array_busy 1->0.
  - done pulse, PE_end=63.
- q_len=130, r_len=5: block_num steps 0,1,2 with three ACK/LOAD/STREAM rounds. Block 2 S is 0 for indices 130..191. PE_end=1.
- q_len=0, or q_len=513 with MAX_BLOCKS=8: no new_seq/ack; done and err high in the same cycle within 2 cycles of start.
- start pulsed during STREAM_R: ignored, and the sequence completes exactly as in the first scenario.
- reset_i low during LOAD_Q: all outputs are 0 immediately. A start after release produces a full, correct sequence.
- array_busy held low for 20 cycles after STREAM_R: the controller stays in DRAIN, with no ack, until busy rises and falls.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - query/reference sequencing controller for the systolic alignment array
module systolic_seq_ctrl #(
    parameter int N             = 64,
    parameter int LOG_N         = 6,
    parameter int BP_WIDTH      = 2,
    parameter int ADDRESS_WIDTH = 11,
    parameter int MAX_BLOCKS    = 8,
    parameter int BLK_WIDTH     = 3
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic                         start,
    input  logic [LOG_N+BLK_WIDTH:0]     q_len,
    input  logic [ADDRESS_WIDTH-1:0]     r_len,
    output logic [LOG_N+BLK_WIDTH-1:0]   q_addr,
    input  logic [BP_WIDTH-1:0]          q_data,
    output logic [ADDRESS_WIDTH-1:0]     r_addr,
    input  logic [BP_WIDTH-1:0]          r_data,
    output logic [BP_WIDTH-1:0]          S,
    output logic [BP_WIDTH-1:0]          T,
    output logic                         s_update,
    output logic                         valid,
    output logic                         ack,
    output logic                         new_seq,
    output logic [LOG_N-1:0]             PE_end,
    input  logic                         array_busy,
    output logic [BLK_WIDTH-1:0]         block_num,
    output logic                         ctrl_busy,
    output logic                         done,
    output logic                         err
);
    localparam int QW = LOG_N + BLK_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, ACK, LOAD_Q, STREAM_R, DRAIN, FIN} state_t;
    state_t state;

    logic [QW-1:0]            q_len_l;
    logic [ADDRESS_WIDTH-1:0] r_len_l;
    logic [BLK_WIDTH:0]       nblk;
    logic [LOG_N-1:0]         q_idx;
    logic [LOG_N-1:0]         cnt;
    logic                     q_rd1;
    logic                     q_pad1;
    logic                     r_issue;
    logic                     r_rd1;
    logic                     saw_busy;
    logic                     q_issue;
    logic                     bad_req;

    // Query reads start in ACK so the first S lands one cycle after LOAD_Q entry.
    assign q_issue   = (state == ACK) || ((state == LOAD_Q) && (cnt != LOG_N'(N-1)));
    assign q_addr    = {block_num, q_idx};
    assign ctrl_busy = (state != IDLE);
    assign bad_req   = (q_len == '0) || (r_len == '0) || (q_len > QW'(N*MAX_BLOCKS));

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            q_len_l   <= '0;
            r_len_l   <= '0;
            nblk      <= '0;
            q_idx     <= '0;
            cnt       <= '0;
            q_rd1     <= 1'b0;
            q_pad1    <= 1'b0;
            r_issue   <= 1'b0;
            r_rd1     <= 1'b0;
            saw_busy  <= 1'b0;
            r_addr    <= '0;
            S         <= '0;
            T         <= '0;
            s_update  <= 1'b0;
            valid     <= 1'b0;
            ack       <= 1'b0;
            new_seq   <= 1'b0;
            PE_end    <= '0;
            block_num <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            new_seq <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;

            q_rd1    <= q_issue;
            q_pad1   <= ({1'b0, block_num, q_idx} >= q_len_l);
            s_update <= q_rd1;
            S        <= (q_rd1 && !q_pad1) ? q_data : '0;

            r_rd1 <= r_issue;
            valid <= r_rd1;
            T     <= r_rd1 ? r_data : '0;
            ack   <= (state == ACK) || r_rd1;

            if (r_issue) begin
                if (r_addr == r_len_l - ADDRESS_WIDTH'(1))
                    r_issue <= 1'b0;
                else
                    r_addr <= r_addr + ADDRESS_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        PE_end <= q_len[LOG_N-1:0] - LOG_N'(1);
                        if (bad_req) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            q_len_l   <= q_len;
                            r_len_l   <= r_len;
                            nblk      <= q_len[QW-1:LOG_N] + {{BLK_WIDTH{1'b0}}, |q_len[LOG_N-1:0]};
                            new_seq   <= 1'b1;
                            block_num <= '0;
                            q_idx     <= '0;
                            state     <= ACK;
                        end
                    end
                end
                ACK: begin
                    q_idx <= LOG_N'(1);
                    cnt   <= '0;
                    state <= LOAD_Q;
                end
                LOAD_Q: begin
                    cnt <= cnt + LOG_N'(1);
                    if (q_idx != LOG_N'(N-1))
                        q_idx <= q_idx + LOG_N'(1);
                    // Reference reads overlap the last load cycle so T follows S without a gap.
                    if (cnt == LOG_N'(N-2)) begin
                        r_addr  <= '0;
                        r_issue <= 1'b1;
                    end
                    if (cnt == LOG_N'(N-1))
                        state <= STREAM_R;
                end
                STREAM_R: begin
                    if (!r_issue || (r_addr == r_len_l - ADDRESS_WIDTH'(1))) begin
                        saw_busy <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (array_busy) begin
                        saw_busy <= 1'b1;
                    end else if (saw_busy) begin
                        if (({1'b0, block_num} + (BLK_WIDTH+1)'(1)) < nblk) begin
                            block_num <= block_num + BLK_WIDTH'(1);
                            q_idx     <= '0;
                            state     <= ACK;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
